// File: rtl/product_bcd_display.sv
// Signed product to seven-segment decimal display: captures a two's-complement
// product, converts its magnitude with a serial double-dabble and drives the digits.
module product_bcd_display #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Start,
   input  logic [WIDTH-1:0]    Prod,
   output logic                Busy,
   output logic                Valid,
   output logic                Neg,
   output logic [4*DIGITS-1:0] Bcd,
   output logic [6:0]          Seg [0:DIGITS-1],
   output logic [6:0]          SignSeg
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic                 cap_en, load_en, shift_en, done_en;

   logic [WIDTH-1:0]     prod_q, prod_d;
   logic [WIDTH-1:0]     mag_q, mag_d;
   logic [BCD_W-1:0]     scr_q, scr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 negr_q, negr_d;
   logic [BCD_W+WIDTH-1:0] shifted;

   logic                 valid_q, valid_d;
   logic                 neg_q, neg_d;
   logic [BCD_W-1:0]     bcd_q, bcd_d;
   logic [6:0]           sign_q, sign_d;
   logic [6:0]           seg_q [0:DIGITS-1];
   logic [6:0]           seg_d [0:DIGITS-1];
   logic                 hi_zero;

   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int k = 0; k < DIGITS; k++) begin
         if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start) state_d = S_LOAD;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Busy     = (state_q != S_IDLE);
      cap_en   = (state_q == S_IDLE) && Start;
      load_en  = (state_q == S_LOAD);
      shift_en = (state_q == S_SHIFT);
      done_en  = (state_q == S_DONE);
   end

   // Conversion datapath: the mag MSB shifts into the units digit each cycle
   always_comb begin
      prod_d  = cap_en ? Prod : prod_q;
      negr_d  = negr_q;
      mag_d   = mag_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      shifted = '0;
      if (load_en) begin
         negr_d = prod_q[WIDTH-1] & (|prod_q);
         mag_d  = prod_q[WIDTH-1] ? (~prod_q + WIDTH'(1)) : prod_q;
         scr_d  = '0;
         cnt_d  = CNT_W'(WIDTH - 1);
      end else if (shift_en) begin
         shifted = {dd_adjust(scr_q), mag_q} << 1;
         scr_d   = shifted[BCD_W+WIDTH-1:WIDTH];
         mag_d   = shifted[WIDTH-1:0];
         cnt_d   = cnt_q - CNT_W'(1);
      end
   end

   // Displayed result only changes on DONE; leading zeros above the units are blanked
   always_comb begin
      valid_d = done_en;
      bcd_d   = done_en ? scr_q : bcd_q;
      neg_d   = done_en ? negr_q : neg_q;
      sign_d  = done_en ? (negr_q ? 7'h3F : 7'h7F) : sign_q;
      hi_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         hi_zero  = hi_zero & (scr_q[4*k +: 4] == 4'd0);
         seg_d[k] = seg_q[k];
         if (done_en) seg_d[k] = ((k != 0) && hi_zero) ? 7'h7F : seg7(scr_q[4*k +: 4]);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         prod_q  <= '0;
         mag_q   <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         negr_q  <= 1'b0;
         valid_q <= 1'b0;
         neg_q   <= 1'b0;
         bcd_q   <= '0;
         sign_q  <= 7'h7F;
         for (int k = 0; k < DIGITS; k++) seg_q[k] <= (k == 0) ? 7'h40 : 7'h7F;
      end else begin
         prod_q  <= prod_d;
         mag_q   <= mag_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         negr_q  <= negr_d;
         valid_q <= valid_d;
         neg_q   <= neg_d;
         bcd_q   <= bcd_d;
         sign_q  <= sign_d;
         for (int k = 0; k < DIGITS; k++) seg_q[k] <= seg_d[k];
      end
   end

   assign Valid   = valid_q;
   assign Neg     = neg_q;
   assign Bcd     = bcd_q;
   assign SignSeg = sign_q;
   assign Seg     = seg_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Scoreboard bench for product_bcd_display: an arithmetic decimal model predicts
// each conversion, a monitor compares every cycle against expected or held values.
module tb_product_bcd_display;

   logic        Clk, Reset, Start;
   logic [15:0] Prod;
   logic        Busy, Valid, Neg;
   logic [19:0] Bcd;
   logic [6:0]  Seg [0:4];
   logic [6:0]  SignSeg;

   product_bcd_display #(.WIDTH(16), .DIGITS(5)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Prod(Prod),
      .Busy(Busy), .Valid(Valid), .Neg(Neg), .Bcd(Bcd),
      .Seg(Seg), .SignSeg(SignSeg)
   );

   typedef struct {
      logic [19:0] bcd;
      logic        neg;
      logic [34:0] seg;
      logic [6:0]  sign;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   exp_t held, rst_exp;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   free_at = 0;
   int   busy_lo = 1;
   int   busy_hi = 0;
   logic [6:0] segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic [15:0] corners [0:9] = '{16'h0000, 16'hFFFF, 16'h4000, 16'h8000, 16'h7FFF,
                                  16'h0001, 16'h000A, 16'hFFF6, 16'h0063, 16'h0064};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   function automatic logic [34:0] seg_pk();
      return {Seg[4], Seg[3], Seg[2], Seg[1], Seg[0]};
   endfunction

   // Signed value -> decimal digits by division, blanking by comparing against powers of ten
   function automatic exp_t model(input logic [15:0] p);
      exp_t e;
      int   v, m, d, pw;
      v  = $signed(p);
      m  = (v < 0) ? -v : v;
      e.neg  = (v < 0);
      e.sign = e.neg ? 7'h3F : 7'h7F;
      e.bcd  = '0;
      e.seg  = '0;
      e.due  = 0;
      pw = 1;
      for (int k = 0; k < 5; k++) begin
         d = (m / pw) % 10;
         e.bcd[4*k +: 4] = 4'(d);
         e.seg[7*k +: 7] = (k > 0 && m < pw) ? 7'h7F : segtab[d];
         pw = pw * 10;
      end
      return e;
   endfunction

   task automatic check_reset(input string nm);
      chk({nm, "_valid"}, Valid, 0);
      chk({nm, "_busy"}, Busy, 0);
      chk({nm, "_neg"}, Neg, rst_exp.neg);
      chk({nm, "_bcd"}, Bcd, rst_exp.bcd);
      chk({nm, "_seg"}, seg_pk(), rst_exp.seg);
      chk({nm, "_sign"}, SignSeg, rst_exp.sign);
   endtask

   // Caller is positioned at a falling edge; Start is sampled on the next rising edge
   task automatic start_conv(input logic [15:0] p);
      exp_t ex;
      int   e;
      Start = 1'b1;
      Prod  = p;
      e = cyc + 1;
      if (e >= free_at) begin
         ex = model(p);
         ex.due = e + 18;
         exp_q.push_back(ex);
         busy_lo = e;
         busy_hi = e + 17;
         free_at = e + 19;
      end
      @(negedge Clk);
      Start = 1'b0;
   endtask

   task automatic wait_done();
      while (cyc < free_at - 1) @(negedge Clk);
   endtask

   task automatic do_reset(input string nm);
      Reset = 1'b0;
      exp_q.delete();
      busy_lo = 1;
      busy_hi = 0;
      free_at = 0;
      held = rst_exp;
      #1 check_reset(nm);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
   endtask

   // Monitor
   initial begin
      bit   exp_v;
      exp_t cur;
      forever begin
         @(posedge Clk);
         cyc++;
         #1;
         exp_v = (exp_q.size() > 0) && (cyc == exp_q[0].due);
         cur = exp_v ? exp_q[0] : held;
         chk("valid", Valid, exp_v);
         chk("busy", Busy, (cyc >= busy_lo) && (cyc <= busy_hi));
         chk("bcd", Bcd, cur.bcd);
         chk("neg", Neg, cur.neg);
         chk("seg", seg_pk(), cur.seg);
         chk("signseg", SignSeg, cur.sign);
         if (exp_v) held = exp_q.pop_front();
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      Reset = 1'b1;
      Start = 1'b0;
      Prod  = '0;
      rst_exp = '{bcd: 20'h0, neg: 1'b0, seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                  sign: 7'h7F, due: 0};
      held = rst_exp;
      #2 Reset = 1'b0;
      #1 check_reset("rst_init");
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < 10; i++) begin
         start_conv(corners[i]);
         wait_done();
         @(negedge Clk);
      end

      start_conv(16'h3F01);
      repeat (3) @(negedge Clk);
      start_conv(16'h1234);
      Prod = 16'hAAAA;
      wait_done();
      start_conv(16'hFF80);
      wait_done();
      @(negedge Clk);

      for (int i = 0; i < 24; i++) begin
         start_conv(16'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 14)) @(negedge Clk);
            start_conv(16'($urandom));
         end
         wait_done();
         repeat ($urandom_range(0, 2)) @(negedge Clk);
      end

      start_conv(16'($urandom));
      repeat (6) @(negedge Clk);
      do_reset("rst_mid");
      @(negedge Clk);
      start_conv(16'hFCF7);
      wait_done();
      repeat (3) @(negedge Clk);

      chk("drain", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
